apexii_ddio_bidir_sched: RTL and testbench

APEXII_DDIO_BIDIR_SCHED -- requirements
Module: apexii_ddio_bidir_sched

---
 rtl/apexii_ddio_bidir_sched.sv | 201 ++++++++++++++++++++
 tb/tb_apexii_ddio_bidir_sched.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/apexii_ddio_bidir_sched.sv
// Burst scheduler for a bidirectional DDIO pin group shared by two requesters.
// Grants one burst at a time, inserts turnaround idle cycles on direction
// changes, registers write data onto the atom and captures read data from it.
// Optional feature macro: DDIO_SCHED_OE_EXTEND_EN keeps ddio_oe asserted for
// one extra cycle after the last write beat, holding the last data word.
module apexii_ddio_bidir_sched #(
    parameter int WIDTH      = 8,
    parameter int TURNAROUND = 2,
    parameter int LENW       = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       req,
    input  logic             dir0,
    input  logic             dir1,
    input  logic [LENW-1:0]  len0,
    input  logic [LENW-1:0]  len1,
    input  logic [WIDTH-1:0] wr_h0,
    input  logic [WIDTH-1:0] wr_l0,
    input  logic [WIDTH-1:0] wr_h1,
    input  logic [WIDTH-1:0] wr_l1,
    output logic [1:0]       gnt,
    output logic [1:0]       beat_rdy,
    output logic [1:0]       rd_valid,
    output logic [WIDTH-1:0] rd_data,
    output logic             ddio_oe,
    output logic             ddio_clkena,
    output logic [WIDTH-1:0] ddio_datain_h,
    output logic [WIDTH-1:0] ddio_datain_l,
    input  logic [WIDTH-1:0] ddio_combout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TURN = 2'd1,
        XFER = 2'd2
    } state_t;

    // Turnaround counter is loaded with TURNAROUND-1; one extra cycle may be
    // added when an extended oe overlaps the first turnaround cycle.
    localparam logic [3:0] TURN_LOAD = 4'(TURNAROUND - 1);

    state_t            state_r;
    logic              ptr_r;
    logic              last_dir_r;
    logic              gsel_r;
    logic              dir_r;
    logic [LENW-1:0]   cnt_r;
    logic [3:0]        turn_cnt_r;
    logic              oe_ext_r;
    logic [1:0]        gnt_r;
    logic [1:0]        beat_rdy_r;
    logic [1:0]        rd_valid_r;
    logic [WIDTH-1:0]  rd_data_r;
    logic              oe_r;
    logic              clkena_r;
    logic [WIDTH-1:0]  datain_h_r;
    logic [WIDTH-1:0]  datain_l_r;

    logic              gsel_s;
    logic              dir_s;
    logic [LENW-1:0]   len_s;
    logic [1:0]        grant_hot_s;
    logic [1:0]        beat_hot_s;
    logic [WIDTH-1:0]  wr_h_s;
    logic [WIDTH-1:0]  wr_l_s;

    // Arbitration: single requester wins outright, a tie goes to the pointer.
    always_comb begin
        gsel_s = 1'b0;
        case (req)
            2'b01:   gsel_s = 1'b0;
            2'b10:   gsel_s = 1'b1;
            2'b11:   gsel_s = ptr_r;
            default: gsel_s = 1'b0;
        endcase
        if (gsel_s) begin
            dir_s = dir1;
            len_s = len1;
        end else begin
            dir_s = dir0;
            len_s = len0;
        end
        if (gsel_r) begin
            wr_h_s = wr_h1;
            wr_l_s = wr_l1;
        end else begin
            wr_h_s = wr_h0;
            wr_l_s = wr_l0;
        end
        grant_hot_s = gsel_s ? 2'b10 : 2'b01;
        beat_hot_s  = gsel_r ? 2'b10 : 2'b01;
    end

    // Scheduler FSM with all outputs registered from the transition taken.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r    <= IDLE;
            ptr_r      <= 1'b0;
            last_dir_r <= 1'b0;
            gsel_r     <= 1'b0;
            dir_r      <= 1'b0;
            cnt_r      <= {LENW{1'b0}};
            turn_cnt_r <= 4'd0;
            oe_ext_r   <= 1'b0;
            gnt_r      <= 2'b00;
            beat_rdy_r <= 2'b00;
            rd_valid_r <= 2'b00;
            rd_data_r  <= {WIDTH{1'b0}};
            oe_r       <= 1'b0;
            clkena_r   <= 1'b0;
            datain_h_r <= {WIDTH{1'b0}};
            datain_l_r <= {WIDTH{1'b0}};
        end else begin
            gnt_r      <= 2'b00;
            rd_valid_r <= 2'b00;
            case (state_r)
                IDLE: begin
                    // A pending extension keeps oe high through this cycle.
                    oe_r       <= oe_ext_r;
                    oe_ext_r   <= 1'b0;
                    beat_rdy_r <= 2'b00;
                    clkena_r   <= 1'b0;
                    if (req != 2'b00) begin
                        gnt_r  <= grant_hot_s;
                        ptr_r  <= ~gsel_s;
                        gsel_r <= gsel_s;
                        dir_r  <= dir_s;
                        cnt_r  <= len_s;
                        if (dir_s != last_dir_r) begin
                            state_r    <= TURN;
                            turn_cnt_r <= TURN_LOAD + {3'b000, oe_ext_r};
                        end else begin
                            state_r    <= XFER;
                            beat_rdy_r <= dir_s ? grant_hot_s : 2'b00;
                            clkena_r   <= 1'b1;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                TURN: begin
                    oe_r     <= 1'b0;
                    oe_ext_r <= 1'b0;
                    if (turn_cnt_r == 4'd0) begin
                        state_r    <= XFER;
                        beat_rdy_r <= dir_r ? beat_hot_s : 2'b00;
                        clkena_r   <= 1'b1;
                    end else begin
                        turn_cnt_r <= turn_cnt_r - 4'd1;
                        beat_rdy_r <= 2'b00;
                        clkena_r   <= 1'b0;
                    end
                end
                XFER: begin
                    // clkena stays up one cycle past the final beat.
                    clkena_r <= 1'b1;
                    oe_r     <= dir_r;
                    if (dir_r) begin
                        datain_h_r <= wr_h_s;
                        datain_l_r <= wr_l_s;
                    end else begin
                        rd_data_r  <= ddio_combout;
                        rd_valid_r <= beat_hot_s;
                    end
                    if (cnt_r == {LENW{1'b0}}) begin
                        state_r    <= IDLE;
                        last_dir_r <= dir_r;
                        beat_rdy_r <= 2'b00;
`ifdef DDIO_SCHED_OE_EXTEND_EN
                        oe_ext_r   <= dir_r;
`else
                        oe_ext_r   <= 1'b0;
`endif
                    end else begin
                        cnt_r      <= cnt_r - {{(LENW-1){1'b0}}, 1'b1};
                        beat_rdy_r <= dir_r ? beat_hot_s : 2'b00;
                        oe_ext_r   <= 1'b0;
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    beat_rdy_r <= 2'b00;
                    oe_r       <= 1'b0;
                    oe_ext_r   <= 1'b0;
                    clkena_r   <= 1'b0;
                end
            endcase
        end
    end

    assign gnt           = gnt_r;
    assign beat_rdy      = beat_rdy_r;
    assign rd_valid      = rd_valid_r;
    assign rd_data       = rd_data_r;
    assign ddio_oe       = oe_r;
    assign ddio_clkena   = clkena_r;
    assign ddio_datain_h = datain_h_r;
    assign ddio_datain_l = datain_l_r;

endmodule

// File: tb/tb_apexii_ddio_bidir_sched.sv
// Directed scoreboard bench for apexii_ddio_bidir_sched (WIDTH=8, LENW=4,
// TURNAROUND=2). Each step pushes the expected output snapshot for the next
// clock edge, advances one clock and pops/compares it. Write data changes
// every cycle as a function of the edge number so captured words are traceable.
module tb_apexii_ddio_bidir_sched;

`ifdef DDIO_SCHED_OE_EXTEND_EN
    localparam bit EXT = 1'b1;
`else
    localparam bit EXT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_n;
    logic [1:0] req;
    logic       dir0, dir1;
    logic [3:0] len0, len1;
    logic [7:0] wr_h0, wr_l0, wr_h1, wr_l1;
    logic [1:0] gnt, beat_rdy, rd_valid;
    logic [7:0] rd_data;
    logic       ddio_oe, ddio_clkena;
    logic [7:0] ddio_datain_h, ddio_datain_l;
    logic [7:0] ddio_combout;

    int errors = 0;
    int checks = 0;
    int ecnt   = 0;

    typedef struct {
        logic [1:0] g;
        logic [1:0] b;
        logic [1:0] rv;
        logic       oe;
        logic       ce;
        logic       dchk;
        logic [7:0] dh;
        logic [7:0] dl;
        logic       rchk;
        logic [7:0] rd;
    } exp_t;

    exp_t exp_q[$];

    apexii_ddio_bidir_sched #(.WIDTH(8), .TURNAROUND(2), .LENW(4)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .req           (req),
        .dir0          (dir0),
        .dir1          (dir1),
        .len0          (len0),
        .len1          (len1),
        .wr_h0         (wr_h0),
        .wr_l0         (wr_l0),
        .wr_h1         (wr_h1),
        .wr_l1         (wr_l1),
        .gnt           (gnt),
        .beat_rdy      (beat_rdy),
        .rd_valid      (rd_valid),
        .rd_data       (rd_data),
        .ddio_oe       (ddio_oe),
        .ddio_clkena   (ddio_clkena),
        .ddio_datain_h (ddio_datain_h),
        .ddio_datain_l (ddio_datain_l),
        .ddio_combout  (ddio_combout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s edge=%0d observed=%h expected=%h", tag, ecnt, obs, exp_v);
        end
    endtask

    // Write data offered for the upcoming edge n: h0=10+n l0=80+n h1=40+n l1=C0+n.
    task automatic drive_wr();
        int n;
        n = ecnt + 1;
        wr_h0 = 8'(8'h10 + n);
        wr_l0 = 8'(8'h80 + n);
        wr_h1 = 8'(8'h40 + n);
        wr_l1 = 8'(8'hC0 + n);
    endtask

    task automatic step();
        exp_t e;
        @(posedge clk);
        ecnt++;
        #1;
        e = exp_q.pop_front();
        chk("gnt",         {6'b000000, gnt},      {6'b000000, e.g});
        chk("beat_rdy",    {6'b000000, beat_rdy}, {6'b000000, e.b});
        chk("rd_valid",    {6'b000000, rd_valid}, {6'b000000, e.rv});
        chk("ddio_oe",     {7'b0000000, ddio_oe},     {7'b0000000, e.oe});
        chk("ddio_clkena", {7'b0000000, ddio_clkena}, {7'b0000000, e.ce});
        if (e.dchk) begin
            chk("datain_h", ddio_datain_h, e.dh);
            chk("datain_l", ddio_datain_l, e.dl);
        end
        if (e.rchk) begin
            chk("rd_data", rd_data, e.rd);
        end
        drive_wr();
    endtask

    // dsel: -1 no data check, 0/1 data of that requester captured 'back'
    // edges before the coming edge, 2 all-zero data.
    task automatic cyc(input logic [1:0] g, input logic [1:0] b, input logic [1:0] rv,
                       input logic oe, input logic ce, input int dsel, input int back,
                       input logic rchk, input logic [7:0] rd);
        exp_t e;
        int edge_n;
        edge_n = ecnt + 1 - back;
        e.g = g; e.b = b; e.rv = rv; e.oe = oe; e.ce = ce;
        e.dchk = (dsel >= 0);
        if (dsel == 0) begin
            e.dh = 8'(8'h10 + edge_n);
            e.dl = 8'(8'h80 + edge_n);
        end else if (dsel == 1) begin
            e.dh = 8'(8'h40 + edge_n);
            e.dl = 8'(8'hC0 + edge_n);
        end else begin
            e.dh = 8'h00;
            e.dl = 8'h00;
        end
        e.rchk = rchk;
        e.rd = rd;
        exp_q.push_back(e);
        step();
    endtask

    task automatic idle0();
        cyc(2'b00, 2'b00, 2'b00, 1'b0, 1'b0, -1, 0, 1'b0, 8'h00);
    endtask

    initial begin
        reset_n = 1'b0; req = 2'b00; dir0 = 1'b0; dir1 = 1'b0;
        len0 = 4'd0; len1 = 4'd0; ddio_combout = 8'hEE;
        drive_wr();

        // Reset state: everything low and zero.
        repeat (3) cyc(2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 2, 0, 1'b1, 8'h00);

        // Write len=3 by requester 0 after reset: 2 TURN, 4 beats, oe lags by 1.
        reset_n = 1'b1; req = 2'b01; dir0 = 1'b1; len0 = 4'd3;
        cyc(2'b01, 2'b00, 2'b00, 1'b0, 1'b0, -1, 0, 1'b0, 8'h00);
        req = 2'b00;
        idle0();
        cyc(2'b00, 2'b01, 2'b00, 1'b0, 1'b1, -1, 0, 1'b0, 8'h00);
        repeat (3) cyc(2'b00, 2'b01, 2'b00, 1'b1, 1'b1, 0, 0, 1'b0, 8'h00);
        cyc(2'b00, 2'b00, 2'b00, 1'b1, 1'b1, 0, 0, 1'b0, 8'h00);
        cyc(2'b00, 2'b00, 2'b00, EXT, 1'b0, EXT ? 0 : -1, 1, 1'b0, 8'h00);
        idle0();

        // Single write beat by requester 1: same direction, no turnaround.
        req = 2'b10; dir1 = 1'b1; len1 = 4'd0;
        cyc(2'b10, 2'b10, 2'b00, 1'b0, 1'b1, -1, 0, 1'b0, 8'h00);
        req = 2'b00;
        cyc(2'b00, 2'b00, 2'b00, 1'b1, 1'b1, 1, 0, 1'b0, 8'h00);
        cyc(2'b00, 2'b00, 2'b00, EXT, 1'b0, EXT ? 1 : -1, 1, 1'b0, 8'h00);

        // Both requesting writes of len 0: grants alternate 0,1,0,1.
        req = 2'b11; dir0 = 1'b1; dir1 = 1'b1; len0 = 4'd0; len1 = 4'd0;
        cyc(2'b01, 2'b01, 2'b00, 1'b0, 1'b1, -1, 0, 1'b0, 8'h00);
        cyc(2'b00, 2'b00, 2'b00, 1'b1, 1'b1, 0, 0, 1'b0, 8'h00);
        cyc(2'b10, 2'b10, 2'b00, EXT, 1'b1, EXT ? 0 : -1, 1, 1'b0, 8'h00);
        cyc(2'b00, 2'b00, 2'b00, 1'b1, 1'b1, 1, 0, 1'b0, 8'h00);
        cyc(2'b01, 2'b01, 2'b00, EXT, 1'b1, EXT ? 1 : -1, 1, 1'b0, 8'h00);
        cyc(2'b00, 2'b00, 2'b00, 1'b1, 1'b1, 0, 0, 1'b0, 8'h00);
        cyc(2'b10, 2'b10, 2'b00, EXT, 1'b1, EXT ? 0 : -1, 1, 1'b0, 8'h00);
        req = 2'b00;
        cyc(2'b00, 2'b00, 2'b00, 1'b1, 1'b1, 1, 0, 1'b0, 8'h00);
        cyc(2'b00, 2'b00, 2'b00, EXT, 1'b0, EXT ? 1 : -1, 1, 1'b0, 8'h00);

        // Write len=1 by requester 0, then read len=2 by requester 1.
        req = 2'b01; dir0 = 1'b1; len0 = 4'd1;
        cyc(2'b01, 2'b01, 2'b00, 1'b0, 1'b1, -1, 0, 1'b0, 8'h00);
        req = 2'b00;
        cyc(2'b00, 2'b01, 2'b00, 1'b1, 1'b1, 0, 0, 1'b0, 8'h00);
        cyc(2'b00, 2'b00, 2'b00, 1'b1, 1'b1, 0, 0, 1'b0, 8'h00);
        req = 2'b10; dir1 = 1'b0; len1 = 4'd2;
        cyc(2'b10, 2'b00, 2'b00, EXT, 1'b0, EXT ? 0 : -1, 1, 1'b0, 8'h00);
        req = 2'b00;
`ifdef DDIO_SCHED_OE_EXTEND_EN
        idle0();
`endif
        idle0();
        cyc(2'b00, 2'b00, 2'b00, 1'b0, 1'b1, -1, 0, 1'b0, 8'h00);
        ddio_combout = 8'h11;
        cyc(2'b00, 2'b00, 2'b10, 1'b0, 1'b1, -1, 0, 1'b1, 8'h11);
        ddio_combout = 8'h22;
        cyc(2'b00, 2'b00, 2'b10, 1'b0, 1'b1, -1, 0, 1'b1, 8'h22);
        ddio_combout = 8'h33;
        cyc(2'b00, 2'b00, 2'b10, 1'b0, 1'b1, -1, 0, 1'b1, 8'h33);
        ddio_combout = 8'hEE;
        idle0();

        // Read len=15: exactly 16 beats then back to IDLE.
        req = 2'b01; dir0 = 1'b0; len0 = 4'd15;
        cyc(2'b01, 2'b00, 2'b00, 1'b0, 1'b1, -1, 0, 1'b0, 8'h00);
        req = 2'b00;
        for (int i = 0; i < 16; i++) begin
            ddio_combout = 8'(8'h30 + i);
            cyc(2'b00, 2'b00, 2'b01, 1'b0, 1'b1, -1, 0, 1'b1, 8'(8'h30 + i));
        end
        ddio_combout = 8'hEE;
        idle0();
        idle0();

        // Reset on the 3rd beat of a 5-beat write aborts the burst.
        req = 2'b01; dir0 = 1'b1; len0 = 4'd4;
        cyc(2'b01, 2'b00, 2'b00, 1'b0, 1'b0, -1, 0, 1'b0, 8'h00);
        req = 2'b00;
        idle0();
        cyc(2'b00, 2'b01, 2'b00, 1'b0, 1'b1, -1, 0, 1'b0, 8'h00);
        cyc(2'b00, 2'b01, 2'b00, 1'b1, 1'b1, 0, 0, 1'b0, 8'h00);
        cyc(2'b00, 2'b01, 2'b00, 1'b1, 1'b1, 0, 0, 1'b0, 8'h00);
        reset_n = 1'b0;
        cyc(2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 2, 0, 1'b1, 8'h00);
        reset_n = 1'b1;
        idle0();
        // Pointer is back at 0, so a tie grants requester 0 (a read, no turn).
        req = 2'b11; dir0 = 1'b0; dir1 = 1'b0; len0 = 4'd0; len1 = 4'd0;
        cyc(2'b01, 2'b00, 2'b00, 1'b0, 1'b1, -1, 0, 1'b0, 8'h00);
        req = 2'b00; ddio_combout = 8'h5A;
        cyc(2'b00, 2'b00, 2'b01, 1'b0, 1'b1, -1, 0, 1'b1, 8'h5A);
        ddio_combout = 8'hEE;
        idle0();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
